wbu_reword: RTL and testbench
=============================

// Module: wbu_reword
// PURPOSE
//  Receive-side inverse of the 36-bit-word-to-6-bit-symbol serializer.
//  - Collects decoded 6-bit symbols from the hex/char decoder and re-packs them into one 36-bit word.
//  - Word length (1..6 symbols) comes from the first symbol of the word.
//  - Sits between the char-to-hexbits decoder and the bus command decompressor/sequencer.
// PARAMETERS
//  LGTIMEOUT   20   log2 of inter-symbol timeout, in i_clk cycles; 0 disables the timeout
// PORTS
//  i_clk         in   1   system clock, all logic on posedge
//  i_rst_n       in   1   reset, asynchronous assert, active low
//  i_stb         in   1   symbol valid, one cycle per symbol; no backpressure
//  i_nl_hexbits  in   7   [6]=newline/sync flag, [5:0]=symbol
//  o_stb         out  1   one-cycle pulse: o_word valid
//  o_word        out  36  assembled word, first symbol in [35:30]
//  o_err         out  1   one-cycle pulse: partial word discarded (newline or timeout)
//  o_busy        out  1   high while a word is partially collected
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): o_stb=0, o_word=0, o_err=0, o_busy=0, state=IDLE, counters=0.
//  - Length decode on first symbol s=[5:0], giving len:
//      s[5:3]=000 -> 1
//      s[5:2]=0010 -> 6
//      s[5:2]=0011 -> 2+s[1:0]
//      s[5:4]=01 -> 2
//      s[5:4]=10 -> 1
//      s[5:4]=11 -> 6
//  - Word is left-aligned: symbol k lands in [35-6k:30-6k]; unused low bits are zero.
//  - FSM states:
//      IDLE, i_stb and [6]=0: latch symbol into [35:30], zero [29:0], r_rem<=len-1.
//        If len==1, pulse o_stb next cycle and stay IDLE; else go to COLLECT.
//      IDLE, i_stb and [6]=1: ignored, no output.
//      COLLECT, i_stb and [6]=0: shift symbol into the next slot, r_rem<=r_rem-1.
//        When r_rem==1, the word completes: o_stb pulses next cycle and the FSM returns to IDLE.
//      COLLECT, i_stb and [6]=1: discard the partial word, pulse o_err, go to IDLE.
//        o_word is not updated.
//  - Latency: o_stb is high exactly one cycle after the i_stb carrying the final symbol.
//    o_word holds its value until the next completed word.
//  - A back-to-back symbol in the cycle o_stb is high is accepted normally as the first symbol of the next word.
//  - Timeout (LGTIMEOUT>0):
//    - Counter clears on every i_stb and counts only in COLLECT.
//    - At all-ones it pulses o_err and returns to IDLE.
//    - If i_stb arrives in the expiry cycle, the symbol wins: it is accepted and the counter clears.
//  - o_busy = (state==COLLECT).
//  - o_stb and o_err are never high together.
//  - Reset mid-word: partial word lost, no o_err.
// STRUCTURE
//  - Shared package wbu_pkg holds:
//    - the length-decode function wbu_word_len(sym[5:0]) -> [2:0], also used by the serializer;
//    - constant WBU_NL = 7'h40.
//  - No sub-module; a single FSM with a shift register, a remaining-count register and a timeout counter.
// TESTING
//  - Len 6: symbols 08,01,02,03,04,05 -> o_stb once, o_word=36'h201083105, 1 cycle after last i_stb.
//  - Len 2: 10,3F -> o_word=36'h43F000000. Len 3: 0D,01,02 -> o_word=36'h341080000.
//  - Len 1: 20 -> o_word=36'h800000000, o_stb on the next cycle, o_busy never set.
//  - Abort: 08,01,(NL 40) -> o_err pulse, no o_stb; then 10,3F -> 36'h43F000000.
//  - Timeout (LGTIMEOUT=4): 08 then idle 15 cycles -> o_err, IDLE.
//    Same with symbol on the expiry cycle -> no o_err.
//  - Async reset asserted mid-word -> all outputs 0 immediately; next 00 -> o_word=36'h0, o_stb.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared definitions for the wishbone-over-UART word/symbol path.
// Both the serializer and the receive-side re-packer use the length decode below.
package wbu_pkg;

  localparam logic [6:0] WBU_NL = 7'h40;

  typedef enum logic {
    StIdle,
    StCollect
  } wbu_state_e;

  // Number of 6-bit symbols (1..6) in a word, decoded from its first symbol.
  function automatic logic [2:0] wbu_word_len(input logic [5:0] sym);
    logic [2:0] len;
    if (sym[5:3] == 3'b000) begin
      len = 3'd1;
    end else if (sym[5:2] == 4'b0010) begin
      len = 3'd6;
    end else if (sym[5:2] == 4'b0011) begin
      len = 3'd2 + {1'b0, sym[1:0]};
    end else if (sym[5:4] == 2'b01) begin
      len = 3'd2;
    end else if (sym[5:4] == 2'b10) begin
      len = 3'd1;
    end else begin
      len = 3'd6;
    end
    return len;
  endfunction

endpackage

// File: rtl/wbu_reword.sv
// Re-packs decoded 6-bit symbols into left-aligned 36-bit words.
// Partial words are dropped with an o_err pulse on newline or inter-symbol timeout.
module wbu_reword
  import wbu_pkg::*;
#(
  parameter int unsigned LGTIMEOUT = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stb,
  input  logic [6:0]  i_nl_hexbits,
  output logic        o_stb,
  output logic [35:0] o_word,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned TW = (LGTIMEOUT > 0) ? LGTIMEOUT : 1;

  wbu_state_e     state_q, state_d;
  logic [35:0]    buf_q, buf_d;
  logic [2:0]     pos_q, pos_d;
  logic [2:0]     rem_q, rem_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           stb_q, stb_d;
  logic           err_q, err_d;
  logic [35:0]    word_q, word_d;

  logic [5:0]     sym;
  logic           is_nl;
  logic [2:0]     len;
  logic [4:0]     shamt;
  logic [35:0]    slot;
  logic           tmo;

  assign sym   = i_nl_hexbits[5:0];
  assign is_nl = i_nl_hexbits[6];
  assign len   = wbu_word_len(sym);
  // Slot k starts 6*k bits below the top of the word.
  assign shamt = {pos_q, 2'b00} + {1'b0, pos_q, 1'b0};
  assign slot  = {sym, 30'd0} >> shamt;
  assign tmo   = (LGTIMEOUT > 0) && (&tcnt_q);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    tcnt_d  = tcnt_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (i_stb && !is_nl) begin
          buf_d = {sym, 30'd0};
          pos_d = 3'd1;
          rem_d = len - 3'd1;
          if (len == 3'd1) begin
            stb_d  = 1'b1;
            word_d = {sym, 30'd0};
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        // An arriving symbol takes priority over a timeout expiring in the same cycle.
        if (i_stb) begin
          tcnt_d = '0;
          if (is_nl) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            buf_d = buf_q | slot;
            pos_d = pos_q + 3'd1;
            rem_d = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
              stb_d   = 1'b1;
              word_d  = buf_q | slot;
              state_d = StIdle;
            end
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          tcnt_d  = '0;
          state_d = StIdle;
        end else if (LGTIMEOUT > 0) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      pos_q   <= '0;
      rem_q   <= '0;
      tcnt_q  <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      tcnt_q  <= tcnt_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      word_q  <= word_d;
    end
  end

  assign o_stb  = stb_q;
  assign o_err  = err_q;
  assign o_word = word_q;
  assign o_busy = (state_q == StCollect);

endmodule

// File: tb/tb_wbu_reword.sv
// Directed bench for wbu_reword with a short (4-bit) timeout.
module tb_wbu_reword;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stb;
  logic [6:0]  i_nl_hexbits;
  logic        o_stb;
  logic [35:0] o_word;
  logic        o_err;
  logic        o_busy;

  int checks = 0;
  int passed = 0;

  wbu_reword #(.LGTIMEOUT(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stb        (i_stb),
    .i_nl_hexbits (i_nl_hexbits),
    .o_stb        (o_stb),
    .o_word       (o_word),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the symbol's capture edge.
  task automatic put_sym(input logic [6:0] v);
    i_stb        = 1'b1;
    i_nl_hexbits = v;
    @(negedge i_clk);
    i_stb        = 1'b0;
    i_nl_hexbits = 7'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_stb = 1'b0; i_nl_hexbits = 7'h00;
    #1;
    checks++; if (o_stb !== 1'b0) $display("FAIL reset_stb: got %b expected 0", o_stb); else passed++;
    checks++; if (o_word !== 36'h0) $display("FAIL reset_word: got %h expected 0", o_word); else passed++;
    checks++; if (o_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", o_err); else passed++;
    checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else passed++;
    idle(2);
    i_rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_len6();
    logic [6:0] syms [6] = '{7'h08, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05};
    for (int i = 0; i < 5; i++) begin
      put_sym(syms[i]);
      checks++;
      if (o_stb !== 1'b0 || o_busy !== 1'b1)
        $display("FAIL len6_mid%0d: got stb=%b busy=%b expected stb=0 busy=1", i, o_stb, o_busy);
      else passed++;
    end
    put_sym(syms[5]);
    checks++; if (o_stb !== 1'b1) $display("FAIL len6_stb: got %b expected 1", o_stb); else passed++;
    checks++;
    if (o_word !== 36'h201083105) $display("FAIL len6_word: got %h expected 201083105", o_word);
    else passed++;
    checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b0)
      $display("FAIL len6_flags: got busy=%b err=%b expected 0 0", o_busy, o_err);
    else passed++;
    idle(1);
    checks++;
    if (o_stb !== 1'b0 || o_word !== 36'h201083105)
      $display("FAIL len6_hold: got stb=%b word=%h expected stb=0 word=201083105", o_stb, o_word);
    else passed++;
  endtask

  task automatic test_len2_len3();
    put_sym(7'h10);
    put_sym(7'h3F);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h43F000000)
      $display("FAIL len2: got stb=%b word=%h expected 1 43f000000", o_stb, o_word);
    else passed++;
    idle(1);
    put_sym(7'h0D);
    put_sym(7'h01);
    checks++;
    if (o_stb !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL len3_mid: got stb=%b busy=%b expected 0 1", o_stb, o_busy);
    else passed++;
    put_sym(7'h02);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h341080000)
      $display("FAIL len3: got stb=%b word=%h expected 1 341080000", o_stb, o_word);
    else passed++;
    idle(1);
  endtask

  task automatic test_len1_and_nl_idle();
    put_sym(7'h20);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h800000000 || o_busy !== 1'b0)
      $display("FAIL len1: got stb=%b word=%h busy=%b expected 1 800000000 0", o_stb, o_word, o_busy);
    else passed++;
    put_sym(7'h40);
    checks++;
    if (o_stb !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL nl_idle: got stb=%b err=%b busy=%b expected 0 0 0", o_stb, o_err, o_busy);
    else passed++;
    idle(1);
  endtask

  task automatic test_abort();
    put_sym(7'h08);
    put_sym(7'h01);
    put_sym(7'h40);
    checks++;
    if (o_err !== 1'b1 || o_stb !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL abort: got err=%b stb=%b busy=%b expected 1 0 0", o_err, o_stb, o_busy);
    else passed++;
    checks++;
    if (o_word !== 36'h800000000) $display("FAIL abort_word: got %h expected 800000000", o_word);
    else passed++;
    idle(1);
    checks++; if (o_err !== 1'b0) $display("FAIL abort_pulse: got %b expected 0", o_err); else passed++;
    put_sym(7'h10);
    put_sym(7'h3F);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h43F000000)
      $display("FAIL abort_next: got stb=%b word=%h expected 1 43f000000", o_stb, o_word);
    else passed++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    put_sym(7'h20);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h800000000)
      $display("FAIL b2b_first: got stb=%b word=%h expected 1 800000000", o_stb, o_word);
    else passed++;
    put_sym(7'h10);
    checks++;
    if (o_stb !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL b2b_mid: got stb=%b busy=%b expected 0 1", o_stb, o_busy);
    else passed++;
    put_sym(7'h3F);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h43F000000)
      $display("FAIL b2b_second: got stb=%b word=%h expected 1 43f000000", o_stb, o_word);
    else passed++;
    idle(1);
  endtask

  task automatic test_timeout();
    put_sym(7'h08);
    idle(15);
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL tmo_before: got err=%b busy=%b expected 0 1", o_err, o_busy);
    else passed++;
    idle(1);
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_stb !== 1'b0)
      $display("FAIL tmo_expire: got err=%b busy=%b stb=%b expected 1 0 0", o_err, o_busy, o_stb);
    else passed++;
    idle(1);
    checks++; if (o_err !== 1'b0) $display("FAIL tmo_pulse: got %b expected 0", o_err); else passed++;
  endtask

  task automatic test_timeout_rescue();
    put_sym(7'h08);
    idle(15);
    put_sym(7'h01);  // lands on the expiry cycle
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL rescue: got err=%b busy=%b expected 0 1", o_err, o_busy);
    else passed++;
    put_sym(7'h02);
    put_sym(7'h03);
    put_sym(7'h04);
    put_sym(7'h05);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h201083105)
      $display("FAIL rescue_word: got stb=%b word=%h expected 1 201083105", o_stb, o_word);
    else passed++;
    idle(1);
  endtask

  task automatic test_async_reset();
    put_sym(7'h08);
    put_sym(7'h01);
    checks++; if (o_busy !== 1'b1) $display("FAIL ar_pre_busy: got %b expected 1", o_busy); else passed++;
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_stb !== 1'b0 || o_word !== 36'h0 || o_err !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL ar_clear: got stb=%b word=%h err=%b busy=%b expected all 0",
               o_stb, o_word, o_err, o_busy);
    else passed++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    checks++; if (o_err !== 1'b0) $display("FAIL ar_no_err: got %b expected 0", o_err); else passed++;
    idle(1);
    put_sym(7'h00);
    checks++;
    if (o_stb !== 1'b1 || o_word !== 36'h0 || o_err !== 1'b0)
      $display("FAIL ar_next: got stb=%b word=%h err=%b expected 1 0 0", o_stb, o_word, o_err);
    else passed++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_len6();
    test_len2_len3();
    test_len1_and_nl_idle();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_timeout_rescue();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
